// File: rtl/regfile_mp.sv
// Multi-port general register file for the ID stage: NUM_RD combinational read ports,
// two synchronous write ports with bypass, and a post-reset clear sequencer gating 'ready'.
module regfile_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic                 we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [DW-1:0]        wdata0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [DW-1:0]        wdata1,
    input  logic [NUM_RD-1:0]    re,
    input  logic [NUM_RD*AW-1:0] raddr,
    output logic [NUM_RD*DW-1:0] rdata
);
    localparam int         DEPTH    = 1 << AW;
    localparam logic [AW:0] DONE_PTR = (AW+1)'(DEPTH - 1);
    localparam bit         ZR       = (ZERO_R0 != 0);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [AW:0]     clr_ptr_r;
    logic [AW:0]     clr_ptr_s;
    logic            ready_r;
    logic            commit0_s;
    logic            commit1_s;
    logic [AW-1:0]   rd_addr_s;
    logic [DW-1:0]   regs_r [DEPTH];

    assign ready = ready_r;

    // Next-state and clear-pointer logic for the RST -> CLEAR -> READY sequencer
    always_comb begin
        state_s   = state_r;
        clr_ptr_s = clr_ptr_r;
        case (state_r)
            ST_RST: begin
                state_s   = ST_CLEAR;
                clr_ptr_s = '0;
            end
            ST_CLEAR: begin
                clr_ptr_s = clr_ptr_r + (AW+1)'(1);
                if (clr_ptr_r == DONE_PTR) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_s = ST_READY;
            end
            default: begin
                state_s   = ST_RST;
                clr_ptr_s = '0;
            end
        endcase
    end

    // Sequencer state, clear pointer and registered ready flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_RST;
            clr_ptr_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            clr_ptr_r <= clr_ptr_s;
            ready_r   <= (state_s == ST_READY);
        end
    end

    // Port 1 shadows port 0 on an address collision; entry 0 may be read-only zero
    always_comb begin
        commit0_s = we0 && !(ZR && (waddr0 == '0)) && !(we1 && (waddr1 == waddr0));
        commit1_s = we1 && !(ZR && (waddr1 == '0));
    end

    // Register array: cleared one entry per cycle during CLEAR, written only when READY
    always_ff @(posedge clk) begin
        if (rst && (state_r == ST_CLEAR)) begin
            regs_r[clr_ptr_r[AW-1:0]] <= '0;
        end else if (rst && (state_r == ST_READY)) begin
            if (commit0_s) begin
                regs_r[waddr0] <= wdata0;
            end
            if (commit1_s) begin
                regs_r[waddr1] <= wdata1;
            end
        end
    end

    // Combinational read ports; bypass only fires when ready, so it matches what commits
    always_comb begin
        rdata     = '0;
        rd_addr_s = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_s = raddr[k*AW +: AW];
            if (!ready_r) begin
                rdata[k*DW +: DW] = '0;
            end else if (ZR && (rd_addr_s == '0)) begin
                rdata[k*DW +: DW] = '0;
            end else if (!re[k]) begin
                rdata[k*DW +: DW] = '0;
            end else if (we1 && (waddr1 == rd_addr_s)) begin
                rdata[k*DW +: DW] = wdata1;
            end else if (we0 && (waddr0 == rd_addr_s)) begin
                rdata[k*DW +: DW] = wdata0;
            end else begin
                rdata[k*DW +: DW] = regs_r[rd_addr_s];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 4-read-port ZERO_R0=1 instance and a 1-read-port ZERO_R0=0 instance
// share stimulus; a behavioural model is compared every cycle, plus literal spot checks.
module tb_regfile_mp;
    logic         clk = 1'b0;
    logic         rst;
    logic         we0, we1;
    logic [4:0]   waddr0, waddr1;
    logic [31:0]  wdata0, wdata1;
    logic [3:0]   re;
    logic [19:0]  raddr;
    logic [127:0] rdata_a;
    logic [31:0]  rdata_b;
    logic         ready_a, ready_b;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [31:0] m_a [32];
    logic [31:0] m_b [32];
    bit          mrdy = 1'b0;
    int          cnt  = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DW(32), .AW(5), .NUM_RD(4), .ZERO_R0(1)) dut_a (
        .clk(clk), .rst(rst), .ready(ready_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata_a)
    );

    regfile_mp #(.DW(32), .AW(5), .NUM_RD(1), .ZERO_R0(0)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re[0]), .raddr(raddr[4:0]), .rdata(rdata_b)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit zr, input bit ren, input logic [4:0] a,
                                           input logic [31:0] stored);
        if (!mrdy)                  return 32'h0;
        if (zr && a == 5'd0)        return 32'h0;
        if (!ren)                   return 32'h0;
        if (we1 && waddr1 == a)     return wdata1;
        if (we0 && waddr0 == a)     return wdata0;
        return stored;
    endfunction

    // Model: ready after 33 posedges with rst high; array all zero at that point
    always @(posedge clk) begin
        if (!rst) begin
            cnt  = 0;
            mrdy = 1'b0;
        end else if (!mrdy) begin
            cnt++;
            if (cnt == 33) begin
                mrdy = 1'b1;
                for (int i = 0; i < 32; i++) begin
                    m_a[i] = 32'h0;
                    m_b[i] = 32'h0;
                end
            end
        end else begin
            if (we0) begin
                if (waddr0 != 5'd0) m_a[waddr0] = wdata0;
                m_b[waddr0] = wdata0;
            end
            if (we1) begin
                if (waddr1 != 5'd0) m_a[waddr1] = wdata1;
                m_b[waddr1] = wdata1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [4:0] a;
        chk("ready_a", {31'h0, ready_a}, {31'h0, mrdy});
        chk("ready_b", {31'h0, ready_b}, {31'h0, mrdy});
        for (int k = 0; k < 4; k++) begin
            a = raddr[k*5 +: 5];
            chk($sformatf("rdata_a[%0d]", k), rdata_a[k*32 +: 32],
                exp_rd(1'b1, re[k], a, mrdy ? m_a[a] : 32'h0));
        end
        a = raddr[4:0];
        chk("rdata_b", rdata_b, exp_rd(1'b0, re[0], a, mrdy ? m_b[a] : 32'h0));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = 5'd0; waddr1 = 5'd0;
        wdata0 = 32'h0; wdata1 = 32'h0;
    endtask

    // counts posedges until ready; pulses we0 to addr 12 meanwhile
    task automatic measure_ready(input string nm);
        int n;
        n = 0;
        while (!ready_a && n < 100) begin
            re     = 4'hF;
            raddr  = {4{n[4:0]}};
            we0    = n[0];
            waddr0 = 5'd12;
            wdata0 = 32'h1234_5678;
            cyc();
            n++;
        end
        idle();
        chk(nm, n, 32'd33);
    endtask

    initial begin
        rst = 1'b0; re = 4'h0; raddr = 20'h0;
        idle();
        repeat (3) cyc();

        // 1: reset release and full clear, then all entries read zero
        rst = 1'b1;
        measure_ready("ready_latency");
        for (int a = 0; a < 32; a++) begin
            re = 4'hF;
            raddr = {4{a[4:0]}};
            cyc();
        end
        raddr = {4{5'd12}};
        #1;
        chk("cleared_12", rdata_a[31:0], 32'h0);

        // 2: reset dropped mid-CLEAR at clr_ptr=10, sequence restarts
        rst = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        repeat (11) begin
            we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hCAFE_F00D;
            cyc();
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        measure_ready("ready_latency_restart");
        re = 4'hF; raddr = {4{5'd12}};
        #1;
        chk("clear_ignores_we0", rdata_b, 32'h0);

        // 3: write with same-cycle bypass, then stored
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        re = 4'h1; raddr = {4{5'd5}};
        #1;
        chk("bypass_w0", rdata_a[31:0], 32'hDEAD_BEEF);
        cyc();
        idle();
        #1;
        chk("stored_w0", rdata_a[31:0], 32'hDEAD_BEEF);

        // 4: both ports to the same address, port 1 wins; different addresses both commit
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111_1111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222_2222;
        re = 4'hF; raddr = {4{5'd7}};
        #1;
        chk("collide_bypass", rdata_a[63:32], 32'h2222_2222);
        cyc();
        idle();
        #1;
        chk("collide_stored", rdata_b, 32'h2222_2222);
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1111_1111;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h2222_2222;
        cyc();
        idle();
        raddr = {5'd4, 5'd3, 5'd4, 5'd3};
        #1;
        chk("dual_addr3", rdata_a[31:0], 32'h1111_1111);
        chk("dual_addr4", rdata_a[63:32], 32'h2222_2222);

        // 5: entry 0 hardwired on dut_a, ordinary on dut_b
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        raddr = {4{5'd0}};
        #1;
        chk("r0_bypass_b", rdata_b, 32'hFFFF_FFFF);
        cyc();
        idle();
        #1;
        chk("r0_zero_a", rdata_a[95:64], 32'h0);
        chk("r0_stored_b", rdata_b, 32'hFFFF_FFFF);

        // 6: per-port read enables
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hA5A5_A5A5;
        cyc();
        idle();
        re = 4'b1011; raddr = {4{5'd9}};
        #1;
        chk("re_port0", rdata_a[31:0],   32'hA5A5_A5A5);
        chk("re_port1", rdata_a[63:32],  32'hA5A5_A5A5);
        chk("re_port2", rdata_a[95:64],  32'h0);
        chk("re_port3", rdata_a[127:96], 32'hA5A5_A5A5);

        // a few mixed write/read patterns, checked by the model
        for (int i = 0; i < 16; i++) begin
            we0 = i[0]; waddr0 = 5'(i * 3);     wdata0 = 32'h0100_0000 + i;
            we1 = i[1]; waddr1 = 5'(i * 5 + 1); wdata1 = 32'h0200_0000 + i;
            re  = 4'(i ^ 4'hA);
            raddr = {5'(i * 5 + 1), 5'(i * 3), 5'(i), 5'(i * 3)};
            cyc();
        end
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
